if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter and drives the address of the combinational instruction ROM. Selects the next PC from the sequential, jump, jr, branch, exception and interrupt sources. Latches the returned word into the IF/ID pipeline register with stall and flush control.

---
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next fetch address from
// sequential/jump/jr/branch/exception/interrupt sources and fills the IF/ID
// pipeline register with stall and flush control.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h80000004,
  parameter logic [31:0] EXC_VECTOR   = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] IF_PC,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exception,
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_plus4,
  output logic        ID_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        irq_accept;
  logic        redirect;

  // The kernel bit (31) is never touched by the sequential increment.
  assign pc_plus4 = {IF_PC[31], IF_PC[30:0] + 31'd4};

  // Interrupts are masked in kernel mode and lose to a simultaneous exception;
  // gating with reset keeps irq_ack low while the PC is being reloaded.
  assign irq_accept = irq & ~IF_PC[31] & ~exception & ~reset;
  assign irq_ack    = irq_accept;
  assign redirect   = exception | irq_accept | branch_taken | jr | jump;

  // Next-PC selection, highest priority first; any redirect beats stall.
  always_comb begin
    next_pc = pc_plus4;
    if (exception)         next_pc = EXC_VECTOR;
    else if (irq_accept)   next_pc = IRQ_VECTOR;
    else if (branch_taken) next_pc = branch_target;
    else if (jr)           next_pc = jr_target;
    else if (jump)         next_pc = jump_target;
    else if (stall)        next_pc = IF_PC;
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) IF_PC <= RESET_VECTOR;
    else       IF_PC <= next_pc;
  end

  // IF/ID register: flush on redirect (no delay slots), hold on stall, else load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ID_Instruction <= 32'h0;
      ID_PC          <= 32'h0;
      ID_PC_plus4    <= 32'h0;
      ID_valid       <= 1'b0;
      fetch_count    <= 32'h0;
    end else if (redirect) begin
      ID_Instruction <= 32'h0;
      ID_PC          <= 32'h0;
      ID_PC_plus4    <= 32'h0;
      ID_valid       <= 1'b0;
    end else if (!stall) begin
      ID_Instruction <= Instruction;
      ID_PC          <= IF_PC;
      ID_PC_plus4    <= pc_plus4;
      ID_valid       <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: a driver applies directed then random
// control patterns and pushes the expected post-edge state from a behavioural
// model; a monitor pops and compares after every rising edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC;
  logic [31:0] Instruction;
  logic        stall, jump, jr, branch_taken, exception, irq;
  logic [31:0] jump_target, jr_target, branch_target;
  logic        irq_ack;
  logic [31:0] ID_Instruction, ID_PC, ID_PC_plus4, fetch_count;
  logic        ID_valid;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .IF_PC(IF_PC), .Instruction(Instruction),
    .stall(stall), .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exception(exception), .irq(irq), .irq_ack(irq_ack),
    .ID_Instruction(ID_Instruction), .ID_PC(ID_PC), .ID_PC_plus4(ID_PC_plus4),
    .ID_valid(ID_valid), .fetch_count(fetch_count)
  );

  // Combinational instruction ROM: an address-dependent pattern.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16]} ^ 32'h9E3779B9;
  endfunction
  assign Instruction = rom(IF_PC);

  typedef struct {
    logic [31:0] pc, ins, idpc, idp4, cnt;
    logic        v;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;   // model state: what the pipeline holds now
  int   n_pass = 0;
  int   n_total = 0;
  bit   drive_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  // One clock of stimulus: drive at negedge, check irq_ack, queue expected state.
  task automatic cycle(input logic rst, input logic stl, input logic j, input logic [31:0] jt,
                       input logic r, input logic [31:0] rt, input logic b, input logic [31:0] bt,
                       input logic e, input logic i);
    logic        acc;
    logic [31:0] seq;
    exp_t        n;
    @(negedge clk);
    reset = rst; stall = stl; jump = j; jump_target = jt; jr = r; jr_target = rt;
    branch_taken = b; branch_target = bt; exception = e; irq = i;
    #1;
    acc = !rst && i && !m.pc[31] && !e;
    chk("irq_ack", {31'd0, irq_ack}, {31'd0, acc});
    n = m;
    seq = m.pc + 32'd4;
    seq[31] = m.pc[31];
    if (rst) begin
      n.pc = 32'h80000000; n.ins = 0; n.idpc = 0; n.idp4 = 0; n.v = 0; n.cnt = 0;
    end else if (e || acc || b || r || j) begin
      n.pc = e ? 32'h80000008 : acc ? 32'h80000004 : b ? bt : r ? rt : jt;
      n.ins = 0; n.idpc = 0; n.idp4 = 0; n.v = 0;
    end else if (!stl) begin
      n.ins = rom(m.pc); n.idpc = m.pc; n.idp4 = seq; n.v = 1; n.cnt = m.cnt + 1;
      n.pc = seq;
    end
    m = n;
    exp_q.push_back(n);
  endtask

  task automatic idle(input logic rst);
    cycle(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("IF_PC", IF_PC, e.pc);
        chk("ID_Instruction", ID_Instruction, e.ins);
        chk("ID_PC", ID_PC, e.idpc);
        chk("ID_PC_plus4", ID_PC_plus4, e.idp4);
        chk("ID_valid", {31'd0, ID_valid}, {31'd0, e.v});
        chk("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    m = '{pc: 32'h0, ins: 32'h0, idpc: 32'h0, idp4: 32'h0, cnt: 32'h0, v: 1'b0};
    reset = 1; stall = 0; jump = 0; jr = 0; branch_taken = 0; exception = 0; irq = 0;
    jump_target = 0; jr_target = 0; branch_target = 0;
    // reset, then free-run 3 loads
    idle(1); idle(1);
    idle(0); idle(0); idle(0);
    // jump from the reset vector
    idle(1);
    cycle(0, 0, 1, 32'h8000000C, 0, 0, 0, 0, 0, 0);
    idle(0);
    // go to user code at 0x10, stall twice, resume
    cycle(0, 0, 1, 32'h00000010, 0, 0, 0, 0, 0, 0);
    idle(0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    // stall and branch together: branch wins
    cycle(0, 1, 0, 0, 0, 0, 1, 32'h00000040, 0, 0);
    idle(0);
    // interrupt in user mode, then held high in kernel
    cycle(0, 0, 1, 32'h00000020, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // jr back to user from kernel at 0x80000010
    cycle(0, 0, 1, 32'h80000010, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h00000024, 0, 0, 0, 0);
    idle(0);
    // exception with irq in user mode: exception wins, no ack
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // user-space wrap: 0x7FFFFFFC -> 0x00000000
    cycle(0, 0, 0, 0, 1, 32'h7FFFFFFC, 0, 0, 0, 0);
    idle(0); idle(0);
    // kernel-space wrap: 0xFFFFFFFC -> 0x80000000
    cycle(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    // random phase
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] t1, t2, t3;
      t1 = $urandom; t2 = $urandom; t3 = $urandom;
      if ($urandom_range(0, 1) == 0) t2[31] = 1'b0;
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, t1,
            $urandom_range(0, 11) == 0, t2,
            $urandom_range(0, 11) == 0, t3,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 7) == 0);
    end
    idle(0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

endmodule
